// File: rtl/bomb_pkg.sv
// Shared definitions for the bomb scheduler.
// Contents: the slot state encoding, the tile-grid constants and the
// tile-snap helper function that the top level uses.
package bomb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FUSE  = 2'd1,
        ST_PEND  = 2'd2,
        ST_BLAST = 2'd3
    } slot_state_t;

    localparam int               TILE_SIZE = 16;
    localparam int               COORD_W   = 10;
    localparam logic [COORD_W-1:0] COORD_MAX = 10'd1008;

    // Snap a pixel coordinate to the nearest 16-px tile origin. The sum is
    // formed in 11 bits so values near 1023 do not wrap, then clamped so the
    // tile stays inside the 10-bit playfield.
    function automatic logic [COORD_W-1:0] snap_coord(input logic [COORD_W-1:0] p);
        logic [COORD_W:0] s;
        s = ({1'b0, p} + 11'd8) & ~(11'(TILE_SIZE) - 11'd1);
        snap_coord = (s > {1'b0, COORD_MAX}) ? COORD_MAX : s[COORD_W-1:0];
    endfunction

endpackage

// File: rtl/bomb_slot.sv
// One bomb slot: IDLE -> FUSE -> PEND -> BLAST -> IDLE.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   alloc             accept a new bomb into this (IDLE) slot
//   grant             arbiter hands the blast unit to this (PEND) slot
//   new_x, new_y      snapped tile captured on alloc
//   state             current slot state
//   valid             bomb sprite visible (FUSE or PEND), registered
//   blast_done        last cycle of BLAST; the blast unit is released at this edge
//   tile_x, tile_y    stored tile, held after the slot goes idle
module bomb_slot
    import bomb_pkg::*;
#(
    parameter int FUSE_CYCLES  = 300000000,
    parameter int BLAST_CYCLES = 50000000,
    parameter int CNT_W        = 29
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               alloc,
    input  logic               grant,
    input  logic [COORD_W-1:0] new_x,
    input  logic [COORD_W-1:0] new_y,
    output slot_state_t        state,
    output logic               valid,
    output logic               blast_done,
    output logic [COORD_W-1:0] tile_x,
    output logic [COORD_W-1:0] tile_y
);

    localparam logic [CNT_W-1:0] FUSE_LAST  = CNT_W'(FUSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLAST_LAST = CNT_W'(BLAST_CYCLES - 1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nx_s;
    slot_state_t      state_nx_s;

    assign blast_done = (state == ST_BLAST) && (cnt_r == BLAST_LAST);

    // Next-state and counter logic for the slot lifecycle.
    always_comb begin
        state_nx_s = state;
        cnt_nx_s   = cnt_r;
        case (state)
            ST_IDLE: begin
                if (alloc) begin
                    state_nx_s = ST_FUSE;
                    cnt_nx_s   = '0;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_FUSE: begin
                if (cnt_r == FUSE_LAST) begin
                    state_nx_s = ST_PEND;
                    cnt_nx_s   = '0;
                end else begin
                    cnt_nx_s = cnt_r + CNT_W'(1);
                end
            end
            ST_PEND: begin
                if (grant) begin
                    state_nx_s = ST_BLAST;
                    cnt_nx_s   = '0;
                end else begin
                    state_nx_s = ST_PEND;
                end
            end
            ST_BLAST: begin
                if (cnt_r == BLAST_LAST) begin
                    state_nx_s = ST_IDLE;
                    cnt_nx_s   = '0;
                end else begin
                    cnt_nx_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = '0;
            end
        endcase
    end

    // State, counter, sprite-valid and tile registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt_r  <= '0;
            valid  <= 1'b0;
            tile_x <= '0;
            tile_y <= '0;
        end else begin
            state <= state_nx_s;
            cnt_r <= cnt_nx_s;
            valid <= (state_nx_s == ST_FUSE) || (state_nx_s == ST_PEND);
            if ((state == ST_IDLE) && alloc) begin
                tile_x <= new_x;
                tile_y <= new_y;
            end else begin
                tile_x <= tile_x;
                tile_y <= tile_y;
            end
        end
    end

endmodule

// File: rtl/bomb_scheduler.sv
// Bomb lifecycle scheduler between player input and explosion renderer.
// Ports:
//   clk, reset                    clock and synchronous active-high reset
//   place                         bomb button level (rising edge places)
//   b_x, b_y                      player top-left pixel position
//   place_ack, place_nack         one-cycle accept / reject pulses
//   bomb_valid                    per-slot sprite visible (FUSE or PEND)
//   bomb_x_flat, bomb_y_flat      per-slot tile, 10 bits per slot
//   exploding_bomb_x/_y           tile of the bomb owning the blast unit
//   explosion_active              blast unit in use
//   exploding_slot                slot index owning the blast unit
module bomb_scheduler
    import bomb_pkg::*;
#(
    parameter int MAX_BOMBS    = 2,
    parameter int FUSE_CYCLES  = 300000000,
    parameter int BLAST_CYCLES = 50000000,
    parameter int CNT_W        = 29
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         place,
    input  logic [COORD_W-1:0]           b_x,
    input  logic [COORD_W-1:0]           b_y,
    output logic                         place_ack,
    output logic                         place_nack,
    output logic [MAX_BOMBS-1:0]         bomb_valid,
    output logic [COORD_W*MAX_BOMBS-1:0] bomb_x_flat,
    output logic [COORD_W*MAX_BOMBS-1:0] bomb_y_flat,
    output logic [COORD_W-1:0]           exploding_bomb_x,
    output logic [COORD_W-1:0]           exploding_bomb_y,
    output logic                         explosion_active,
    output logic [1:0]                   exploding_slot
);

    logic                 place_q_r;
    logic                 place_rise_s;
    logic [COORD_W-1:0]   snap_x_s;
    logic [COORD_W-1:0]   snap_y_s;
    slot_state_t          slot_state_s [MAX_BOMBS];
    logic [COORD_W-1:0]   slot_x_s     [MAX_BOMBS];
    logic [COORD_W-1:0]   slot_y_s     [MAX_BOMBS];
    logic [MAX_BOMBS-1:0] blast_done_s;
    logic [MAX_BOMBS-1:0] alloc_sel_s;
    logic [MAX_BOMBS-1:0] alloc_s;
    logic [MAX_BOMBS-1:0] grant_s;
    logic                 found_s;
    logic                 dup_s;
    logic                 accept_s;
    logic                 reject_s;
    logic                 busy_s;
    logic                 granted_s;
    logic [COORD_W-1:0]   ex_x_nx_s;
    logic [COORD_W-1:0]   ex_y_nx_s;
    logic [1:0]           ex_slot_nx_s;

    assign place_rise_s = place & ~place_q_r;
    assign snap_x_s     = snap_coord(b_x);
    assign snap_y_s     = snap_coord(b_y);

    // Allocator: lowest IDLE slot, rejecting duplicates of any live tile
    // (a tile still in BLAST counts as occupied).
    always_comb begin
        found_s     = 1'b0;
        dup_s       = 1'b0;
        alloc_sel_s = '0;
        for (int i = 0; i < MAX_BOMBS; i++) begin
            dup_s          = dup_s | ((slot_state_s[i] != ST_IDLE) &&
                                      (slot_x_s[i] == snap_x_s) &&
                                      (slot_y_s[i] == snap_y_s));
            alloc_sel_s[i] = ~found_s & (slot_state_s[i] == ST_IDLE);
            found_s        = found_s | (slot_state_s[i] == ST_IDLE);
        end
        accept_s = place_rise_s & found_s & ~dup_s;
        reject_s = place_rise_s & ~accept_s;
        alloc_s  = accept_s ? alloc_sel_s : '0;
    end

    // Arbiter: grant only when nobody is in BLAST at the start of the cycle,
    // which forces a one-cycle gap between a release and the next grant.
    always_comb begin
        busy_s       = 1'b0;
        granted_s    = 1'b0;
        grant_s      = '0;
        ex_x_nx_s    = exploding_bomb_x;
        ex_y_nx_s    = exploding_bomb_y;
        ex_slot_nx_s = exploding_slot;
        for (int i = 0; i < MAX_BOMBS; i++) begin
            busy_s = busy_s | (slot_state_s[i] == ST_BLAST);
        end
        for (int i = 0; i < MAX_BOMBS; i++) begin
            grant_s[i]   = ~busy_s & ~granted_s & (slot_state_s[i] == ST_PEND);
            granted_s    = granted_s | grant_s[i];
            ex_x_nx_s    = grant_s[i] ? slot_x_s[i] : ex_x_nx_s;
            ex_y_nx_s    = grant_s[i] ? slot_y_s[i] : ex_y_nx_s;
            ex_slot_nx_s = grant_s[i] ? 2'(i) : ex_slot_nx_s;
        end
    end

    // Edge-detect history, handshake pulses and explosion outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            place_q_r        <= 1'b1;
            place_ack        <= 1'b0;
            place_nack       <= 1'b0;
            exploding_bomb_x <= '0;
            exploding_bomb_y <= '0;
            exploding_slot   <= 2'd0;
            explosion_active <= 1'b0;
        end else begin
            place_q_r        <= place;
            place_ack        <= accept_s;
            place_nack       <= reject_s;
            exploding_bomb_x <= ex_x_nx_s;
            exploding_bomb_y <= ex_y_nx_s;
            exploding_slot   <= ex_slot_nx_s;
            explosion_active <= granted_s | (explosion_active & ~(|blast_done_s));
        end
    end

    for (genvar g = 0; g < MAX_BOMBS; g++) begin : g_slot
        bomb_slot #(
            .FUSE_CYCLES (FUSE_CYCLES),
            .BLAST_CYCLES(BLAST_CYCLES),
            .CNT_W       (CNT_W)
        ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .alloc     (alloc_s[g]),
            .grant     (grant_s[g]),
            .new_x     (snap_x_s),
            .new_y     (snap_y_s),
            .state     (slot_state_s[g]),
            .valid     (bomb_valid[g]),
            .blast_done(blast_done_s[g]),
            .tile_x    (slot_x_s[g]),
            .tile_y    (slot_y_s[g])
        );
        assign bomb_x_flat[COORD_W*g +: COORD_W] = slot_x_s[g];
        assign bomb_y_flat[COORD_W*g +: COORD_W] = slot_y_s[g];
    end

endmodule
